opl_timer_bank: RTL

Parametrised bank of up-counting interval timers with per-timer auto-reload/one-shot mode, per-timer masking, shared sticky IRQ, and force-overflow inputs. Decodes its own register writes from the OPL register-write stream and presents an OPL-compatible status byte and an active-low IRQ. The default configuration is two 8-bit timers at the OPL2 tick ratio of 1:4.

---
 rtl/opl_timer_bank_if.sv | 12 +
 rtl/opl_timer_bank.sv | 138 +++++++++++++
 2 files changed

// File: rtl/opl_timer_bank_if.sv
// Register-write bus carried from the OPL write stream into the timer bank.
// The master drives one-cycle write strobes; the timer bank is the slave.
interface opl_timer_bank_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;

    modport master (output wr_valid, wr_addr, wr_data);
    modport slave  (input  wr_valid, wr_addr, wr_data);
endinterface

// File: rtl/opl_timer_bank.sv
// Bank of OPL-style interval timers: reload/one-shot counting, per-timer masks,
// sticky flags, OPL status byte and registered active-low IRQ.
module opl_timer_bank #(
    parameter int NUM_TIMERS      = 2,
    parameter int TIMER_WIDTH     = 8,
    parameter int TICK_INTERVAL0  = 3579,
    parameter int TICK_RATIO      = 4,
    parameter int ADDR_WIDTH      = 9,
    parameter int TIMER_BASE_ADDR = 2,
    parameter int CTRL_ADDR       = 4,
    parameter int MODE_ADDR       = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    opl_timer_bank_if.slave                   wr,
    input  logic [NUM_TIMERS-1:0]             force_overflow,
    output logic [NUM_TIMERS-1:0]             overflow_pulse,
    output logic [NUM_TIMERS*TIMER_WIDTH-1:0] count,
    output logic [7:0]                        status,
    output logic                              irq_n
);
    localparam int MAX_INTERVAL = TICK_INTERVAL0 * (TICK_RATIO ** (NUM_TIMERS - 1));
    localparam int PRESC_W      = (MAX_INTERVAL > 1) ? $clog2(MAX_INTERVAL) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    logic                  ctrl_wr, mode_wr, clear_flags, ctrl_apply;
    logic [NUM_TIMERS-1:0] flags;
    logic                  irq;
    logic                  irq_n_q;

    assign ctrl_wr     = wr.wr_valid && (wr.wr_addr == ADDR_WIDTH'(CTRL_ADDR));
    assign mode_wr     = wr.wr_valid && (wr.wr_addr == ADDR_WIDTH'(MODE_ADDR));
    assign clear_flags = ctrl_wr && wr.wr_data[7];
    assign ctrl_apply  = ctrl_wr && !wr.wr_data[7];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
            localparam int INTERVAL = TICK_INTERVAL0 * (TICK_RATIO ** gi);

            state_e                 state_q, state_d;
            logic [TIMER_WIDTH-1:0] reload_q, count_q, count_d;
            logic [PRESC_W-1:0]     presc_q, presc_d;
            logic                   mask_q, oneshot_q, flag_q, pulse_q;
            logic                   reload_wr, tick, ovf, flag_set;

            assign reload_wr = wr.wr_valid && (wr.wr_addr == ADDR_WIDTH'(TIMER_BASE_ADDR + gi));
            assign tick      = (state_q == RUN) && (presc_q == PRESC_W'(INTERVAL - 1));
            assign ovf       = tick && (&count_q);

            always_comb begin
                state_d = state_q;
                count_d = count_q;
                presc_d = presc_q;
                case (state_q)
                    IDLE: begin
                        presc_d = '0;
                        if (ctrl_apply && wr.wr_data[gi]) begin
                            state_d = RUN;
                            count_d = reload_q;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            presc_d = '0;
                            count_d = ovf ? reload_q : count_q + TIMER_WIDTH'(1);
                        end else begin
                            presc_d = presc_q + PRESC_W'(1);
                        end
                        // An overflow coinciding with a stop still reloads before going idle.
                        if ((ctrl_apply && !wr.wr_data[gi]) || (ovf && oneshot_q)) begin
                            state_d = IDLE;
                            presc_d = '0;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= IDLE;
                    count_q <= '0;
                    presc_q <= '0;
                    pulse_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    count_q <= count_d;
                    presc_q <= presc_d;
                    pulse_q <= ovf;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    reload_q  <= '0;
                    mask_q    <= 1'b0;
                    oneshot_q <= 1'b0;
                end else begin
                    if (reload_wr)  reload_q  <= TIMER_WIDTH'(wr.wr_data);
                    if (ctrl_apply) mask_q    <= wr.wr_data[6-gi];
                    if (mode_wr)    oneshot_q <= wr.wr_data[gi];
                end
            end

            // A set arriving together with a clear wins.
            assign flag_set = (pulse_q || force_overflow[gi]) && !mask_q;

            always_ff @(posedge clk) begin
                if (reset)            flag_q <= 1'b0;
                else if (flag_set)    flag_q <= 1'b1;
                else if (clear_flags) flag_q <= 1'b0;
            end

            assign flags[gi]                                = flag_q;
            assign overflow_pulse[gi]                       = pulse_q;
            assign count[gi*TIMER_WIDTH +: TIMER_WIDTH]     = count_q;
        end
    endgenerate

    assign irq = |flags;

    always_comb begin
        status    = 8'h00;
        status[7] = irq;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            status[6-i] = flags[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) irq_n_q <= 1'b1;
        else       irq_n_q <= ~irq;
    end

    assign irq_n = irq_n_q;
endmodule
